// File: rtl/ofdm_pkg.sv
// Shared types for the OFDM symbol ping-pong buffer: bank lifecycle and default-width words.
package ofdm_pkg;

  localparam int DEF_INPUT_WIDTH = 12;
  localparam int DEF_SCW         = 7;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  typedef logic [4*DEF_INPUT_WIDTH-1:0] sample_t;
  typedef logic [DEF_SCW-1:0]           sym_idx_t;

endpackage

// File: rtl/ofdm_sdp_ram.sv
// Simple dual-port sample RAM, one write port and one registered read port.
module ofdm_sdp_ram #(
  parameter int DW    = 48,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ofdm_symbol_pingpong.sv
// Ping-pong symbol buffer: collects NFFT-sample symbols into two RAM banks and bursts each
// complete symbol to the FFT through a 2-entry registered skid; short symbols are dropped.
module ofdm_symbol_pingpong
  import ofdm_pkg::*;
#(
  parameter int INPUT_WIDTH          = 12,
  parameter int NFFT                 = 2048,
  parameter int SYMBOL_COUNTER_WIDTH = 7,
  parameter int FFT_SHIFT            = 0
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [4*INPUT_WIDTH-1:0]        s_axis_tdata,
  input  logic [SYMBOL_COUNTER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [4*INPUT_WIDTH-1:0]        m_axis_tdata,
  output logic [SYMBOL_COUNTER_WIDTH:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            err_short_symbol,
  output logic [15:0]                     err_count
);

  localparam int DW  = 4*INPUT_WIDTH;
  localparam int SCW = SYMBOL_COUNTER_WIDTH;
  localparam int AW  = $clog2(NFFT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NFFT-1);
  localparam logic [AW-1:0] RD_XOR    = (FFT_SHIFT != 0) ? AW'(NFFT/2) : AW'(0);

  typedef logic [DW-1:0] word_t;
  typedef struct packed {
    word_t        data;
    logic         last;
    logic         bnk;
    logic [SCW:0] user;
  } beat_t;

  bank_state_t    bank_st   [2];
  logic [SCW-1:0] bank_idx  [2];
  logic           bank_last [2];

  // ---------------- write side ----------------
  logic          rdy_en, wr_bank;
  logic [AW-1:0] wr_addr, wr_slot;
  logic          s_fire, restart, short_last, wr_done;

  always_comb begin
    s_axis_tready = rdy_en && (bank_st[wr_bank] == EMPTY || bank_st[wr_bank] == FILLING);
    s_fire        = s_axis_tvalid && s_axis_tready;
    restart       = s_fire && bank_st[wr_bank] == FILLING && s_axis_tuser != bank_idx[wr_bank];
    wr_slot       = restart ? '0 : wr_addr;
    short_last    = s_fire && s_axis_tlast && wr_slot != LAST_ADDR;
    wr_done       = s_fire && !short_last && wr_slot == LAST_ADDR;
  end

  // ---------------- read side ----------------
  logic          rd_bank, rd_issue, rd_vld, pop, push;
  logic [AW-1:0] rd_cnt;
  logic [1:0]    occ_next;
  beat_t         rd_meta, push_beat;
  beat_t         skid [2];
  logic [1:0]    skid_vld;
  word_t         ram_rdata;

  always_comb begin
    pop      = skid_vld[0] && m_axis_tready;
    push     = rd_vld;
    // occupancy the skid will hold after this cycle, before counting a new issue
    occ_next = {1'b0, skid_vld[0]} + {1'b0, skid_vld[1]} + {1'b0, rd_vld} - {1'b0, pop};
    rd_issue = (bank_st[rd_bank] == FULL || (bank_st[rd_bank] == DRAINING && rd_cnt != '0))
               && occ_next < 2'd2;
    push_beat      = rd_meta;
    push_beat.data = ram_rdata;
  end

  ofdm_sdp_ram #(.DW(DW), .DEPTH(2*NFFT)) u_ram (
    .clk   (clk),
    .we    (s_fire),
    .waddr ({wr_bank, wr_slot}),
    .wdata (s_axis_tdata),
    .re    (rd_issue),
    .raddr ({rd_bank, rd_cnt ^ RD_XOR}),
    .rdata (ram_rdata)
  );

  // Bank lifecycle; write, issue and drain always touch different banks in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_st[b]   <= EMPTY;
        bank_idx[b]  <= '0;
        bank_last[b] <= 1'b0;
      end
      rdy_en  <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (s_fire) begin
        if (wr_slot == '0) bank_idx[wr_bank] <= s_axis_tuser;
        if (short_last) begin
          bank_st[wr_bank] <= EMPTY;
          wr_addr          <= '0;
        end else if (wr_done) begin
          bank_st[wr_bank]   <= FULL;
          bank_last[wr_bank] <= s_axis_tlast;
          wr_bank            <= ~wr_bank;
          wr_addr            <= '0;
        end else begin
          bank_st[wr_bank] <= FILLING;
          wr_addr          <= wr_slot + AW'(1);
        end
      end
      if (rd_issue) begin
        bank_st[rd_bank] <= DRAINING;
        rd_cnt           <= rd_cnt + AW'(1);
        if (rd_cnt == LAST_ADDR) rd_bank <= ~rd_bank;
      end
      if (pop && skid[0].last) bank_st[skid[0].bnk] <= EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_meta <= '0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_issue) begin
        rd_meta.data <= '0;
        rd_meta.last <= (rd_cnt == LAST_ADDR);
        rd_meta.bnk  <= rd_bank;
        rd_meta.user <= {bank_last[rd_bank], bank_idx[rd_bank]};
      end
    end
  end

  // Two-entry skid, head always in slot 0 so the m_axis outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid[0]  <= '0;
      skid[1]  <= '0;
      skid_vld <= 2'b00;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!skid_vld[0]) begin skid[0] <= push_beat; skid_vld[0] <= 1'b1; end
          else begin skid[1] <= push_beat; skid_vld[1] <= 1'b1; end
        end
        2'b01: begin
          skid[0]  <= skid[1];
          skid_vld <= {1'b0, skid_vld[1]};
        end
        2'b11: begin
          if (skid_vld[1]) begin skid[0] <= skid[1]; skid[1] <= push_beat; end
          else skid[0] <= push_beat;
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = skid_vld[0];
  assign m_axis_tdata  = skid[0].data;
  assign m_axis_tuser  = skid[0].user;
  assign m_axis_tlast  = skid[0].last;

  // ---------------- errors ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_short_symbol <= 1'b0;
      err_count        <= '0;
    end else begin
      err_short_symbol <= restart || short_last;
      if ((restart || short_last) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule
